// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU selector, funct and aluop encodings shared by the ALU-control block
package alu_ctrl_pkg;

  localparam logic [3:0] OPS_AND     = 4'b0000;
  localparam logic [3:0] OPS_OR      = 4'b0001;
  localparam logic [3:0] OPS_ADD     = 4'b0010;
  localparam logic [3:0] OPS_NOR     = 4'b0100;
  localparam logic [3:0] OPS_MUL     = 4'b0101;
  localparam logic [3:0] OPS_SUB     = 4'b0110;
  localparam logic [3:0] OPS_DIV     = 4'b1000;
  localparam logic [3:0] OPS_SLT     = 4'b1001;
  localparam logic [3:0] OPS_ILLEGAL = 4'b1111;

  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_MUL = 6'b000010;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef enum logic [1:0] {LAT_SINGLE, LAT_MUL, LAT_DIV} lat_sel_t;

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - combinational aluop/funct decode to ALU selector and latency class
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int OPS_W   = 4
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [OPS_W-1:0]   ops,
  output logic               is_illegal,
  output lat_sel_t           lat_sel
);

  always_comb begin
    ops        = OPS_W'(OPS_ILLEGAL);
    is_illegal = 1'b1;
    case (aluop)
      ALUOP_MEM: begin
        ops        = OPS_W'(OPS_ADD);
        is_illegal = 1'b0;
      end
      ALUOP_BR: begin
        ops        = OPS_W'(OPS_SUB);
        is_illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        is_illegal = 1'b0;
        case (funct)
          FUNCT_W'(FUNCT_AND): ops = OPS_W'(OPS_AND);
          FUNCT_W'(FUNCT_OR):  ops = OPS_W'(OPS_OR);
          FUNCT_W'(FUNCT_ADD): ops = OPS_W'(OPS_ADD);
          FUNCT_W'(FUNCT_NOR): ops = OPS_W'(OPS_NOR);
          FUNCT_W'(FUNCT_MUL): ops = OPS_W'(OPS_MUL);
          FUNCT_W'(FUNCT_SUB): ops = OPS_W'(OPS_SUB);
          FUNCT_W'(FUNCT_DIV): ops = OPS_W'(OPS_DIV);
          FUNCT_W'(FUNCT_SLT): ops = OPS_W'(OPS_SLT);
          default: begin
            ops        = OPS_W'(OPS_ILLEGAL);
            is_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ops        = OPS_W'(OPS_ILLEGAL);
        is_illegal = 1'b1;
      end
    endcase
  end

  // Latency class follows the selector, so illegal decodes are always single-cycle.
  always_comb begin
    lat_sel = LAT_SINGLE;
    if (ops == OPS_W'(OPS_MUL))
      lat_sel = LAT_MUL;
    else if (ops == OPS_W'(OPS_DIV))
      lat_sel = LAT_DIV;
  end

endmodule

// File: rtl/alu_control_mc.sv
// rtl/alu_control_mc.sv - multi-cycle ALU-control decoder with valid/ready issue and stall output
module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int OPS_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               flush,
  output logic [OPS_W-1:0]   ops,
  output logic               out_valid,
  output logic               busy,
  output logic               illegal
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'((DIV_LAT > 1) ? DIV_LAT - 2 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [OPS_W-1:0] dec_ops;
  logic             dec_illegal;
  lat_sel_t         dec_lat;
  logic             multi;
  logic [CNT_W-1:0] cnt_load;
  logic             accept;

  alu_funct_decode #(
    .FUNCT_W (FUNCT_W),
    .OPS_W   (OPS_W)
  ) u_decode (
    .aluop      (aluop),
    .funct      (funct),
    .ops        (dec_ops),
    .is_illegal (dec_illegal),
    .lat_sel    (dec_lat)
  );

  // A latency of 1 configured for mul/div collapses that op onto the single-cycle path.
  always_comb begin
    multi    = 1'b0;
    cnt_load = '0;
    case (dec_lat)
      LAT_MUL: begin
        multi    = (MUL_LAT > 1);
        cnt_load = MUL_CNT;
      end
      LAT_DIV: begin
        multi    = (DIV_LAT > 1);
        cnt_load = DIV_CNT;
      end
      default: begin
        multi    = 1'b0;
        cnt_load = '0;
      end
    endcase
  end

  assign req_ready = (state == IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ops       <= OPS_W'(OPS_ILLEGAL);
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ops <= dec_ops;
            if (multi) begin
              state <= BUSY;
              cnt   <= cnt_load;
            end else begin
              out_valid <= 1'b1;
              illegal   <= dec_illegal;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state     <= IDLE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
